// File: rtl/battleship_pkg.sv
// Shared constants and types for the battleship game-state engine.
package battleship_pkg;

    localparam int GRID_DEFAULT      = 10;
    localparam int MAX_SHIPS_DEFAULT = 17;

    localparam logic [1:0] CELL_WATER = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_MISS  = 2'b10;
    localparam logic [1:0] CELL_HIT   = 2'b11;

    localparam logic [1:0] RES_MISS    = 2'b00;
    localparam logic [1:0] RES_HIT     = 2'b01;
    localparam logic [1:0] RES_REPEAT  = 2'b10;
    localparam logic [1:0] RES_INVALID = 2'b11;

    typedef enum logic [2:0] {
        ST_SETUP,
        ST_PLAY,
        ST_CHECK,
        ST_UPDATE,
        ST_OVER
    } state_t;

endpackage

// File: rtl/battleship_board_if.sv
// Game I/O bundle between the controller (master) and the board engine (slave).
interface battleship_board_if;
    import battleship_pkg::*;

    logic        place_valid;
    logic        place_player;
    logic [3:0]  place_row;
    logic [3:0]  place_col;
    logic        start;
    // A shot is taken on the clock edge where fire_valid && fire_ready are both
    // high; fire_row/fire_col must be stable while fire_valid is asserted.
    logic        fire_valid;
    logic        fire_ready;
    logic [3:0]  fire_row;
    logic [3:0]  fire_col;
    logic        result_valid;
    logic [1:0]  result_code;
    logic [19:0] A, B, C, D, E, F, G, H, I, J;
    logic        playerTurn;
    logic        game_over;
    logic        winner;
    state_t      dbg_state;

    modport master (
        output place_valid, place_player, place_row, place_col, start,
        output fire_valid, fire_row, fire_col,
        input  fire_ready, result_valid, result_code,
        input  A, B, C, D, E, F, G, H, I, J,
        input  playerTurn, game_over, winner, dbg_state
    );

    modport slave (
        input  place_valid, place_player, place_row, place_col, start,
        input  fire_valid, fire_row, fire_col,
        output fire_ready, result_valid, result_code,
        output A, B, C, D, E, F, G, H, I, J,
        output playerTurn, game_over, winner, dbg_state
    );

endinterface

// File: rtl/board_bank.sv
// One player's board: GRIDxGRID 2-bit cells, combinational read, synchronous write.
module board_bank
    import battleship_pkg::*;
#(
    parameter int GRID = GRID_DEFAULT
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           we_i,
    input  logic [3:0]                     wr_row_i,
    input  logic [3:0]                     wr_col_i,
    input  logic [1:0]                     wr_data_i,
    input  logic [3:0]                     rd_row_i,
    input  logic [3:0]                     rd_col_i,
    output logic [1:0]                     rd_data_o,
    output logic [GRID-1:0][2*GRID-1:0]    rows_o
);

    localparam logic [3:0] LAST = 4'(GRID - 1);

    // Column 0 sits in the most significant pair of each row.
    logic [GRID-1:0][2*GRID-1:0] rows_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rows_q <= '0;
        end else if (we_i && wr_row_i <= LAST && wr_col_i <= LAST) begin
            rows_q[wr_row_i][2*(GRID-1-int'(wr_col_i)) +: 2] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_o = CELL_WATER;
        if (rd_row_i <= LAST && rd_col_i <= LAST) begin
            rd_data_o = rows_q[rd_row_i][2*(GRID-1-int'(rd_col_i)) +: 2];
        end
    end

    assign rows_o = rows_q;

endmodule

// File: rtl/battleship_board.sv
// Two-player battleship engine feeding the board renderer.
// Build option: BATTLESHIP_SHOW_SHIPS_EN shows ship cells on the buses (no fog-of-war).
module battleship_board
    import battleship_pkg::*;
#(
    parameter int GRID      = GRID_DEFAULT,
    parameter int MAX_SHIPS = MAX_SHIPS_DEFAULT
) (
    input  logic               clock50,
    input  logic               reset,
    battleship_board_if.slave  bus
);

    localparam logic [3:0] LAST    = 4'(GRID - 1);
    localparam logic [4:0] MAX_CNT = 5'(MAX_SHIPS);
`ifdef BATTLESHIP_SHOW_SHIPS_EN
    localparam bit FOG_EN = 1'b0;
`else
    localparam bit FOG_EN = 1'b1;
`endif

    state_t                      state_q, state_d;
    logic                        turn_q, turn_d, toggle_q, toggle_d;
    logic [3:0]                  shot_row_q, shot_row_d, shot_col_q, shot_col_d;
    logic [1:0]                  code_q, code_d, res_code_q, res_code_d;
    logic                        res_valid_q, res_valid_d;
    logic                        over_q, over_d, winner_q, winner_d;
    logic [1:0][4:0]             ship_cnt_q, ship_cnt_d, hit_cnt_q, hit_cnt_d;
    logic [GRID-1:0][2*GRID-1:0] rows_q, rows_d;

    logic [1:0][GRID-1:0][2*GRID-1:0] bank_rows;
    logic [1:0][1:0]                  rd_data;
    logic [1:0]                       bank_we;
    logic [3:0]                       acc_row, acc_col;
    logic                             target, place_ok, shot_we, win;
    logic [1:0]                       shot_cell;
    logic [4:0]                       hits_new;

    assign target    = ~turn_q;
    assign acc_row   = (state_q == ST_SETUP) ? bus.place_row : shot_row_q;
    assign acc_col   = (state_q == ST_SETUP) ? bus.place_col : shot_col_q;
    assign place_ok  = (state_q == ST_SETUP) && bus.place_valid &&
                       bus.place_row <= LAST && bus.place_col <= LAST &&
                       rd_data[bus.place_player] == CELL_WATER &&
                       ship_cnt_q[bus.place_player] < MAX_CNT;
    assign shot_we   = (state_q == ST_UPDATE) && (code_q == RES_MISS || code_q == RES_HIT);
    assign shot_cell = (code_q == RES_HIT) ? CELL_HIT : CELL_MISS;
    assign hits_new  = hit_cnt_q[turn_q] + {4'd0, code_q == RES_HIT};
    assign win       = (state_q == ST_UPDATE) && (code_q == RES_HIT) &&
                       (hits_new == ship_cnt_q[target]);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b] = (place_ok && bus.place_player == 1'(b)) ||
                            (shot_we && target == 1'(b));
        board_bank #(.GRID(GRID)) u_bank (
            .clk_i     (clock50),
            .rst_i     (reset),
            .we_i      (bank_we[b]),
            .wr_row_i  (acc_row),
            .wr_col_i  (acc_col),
            .wr_data_i ((state_q == ST_SETUP) ? CELL_SHIP : shot_cell),
            .rd_row_i  (acc_row),
            .rd_col_i  (acc_col),
            .rd_data_o (rd_data[b]),
            .rows_o    (bank_rows[b])
        );
    end

    always_ff @(posedge clock50) begin
        if (reset) state_q <= ST_SETUP;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SETUP:  if (bus.start && ship_cnt_q[0] != 5'd0 && ship_cnt_q[1] != 5'd0)
                           state_d = ST_PLAY;
            ST_PLAY:   if (bus.fire_valid) state_d = ST_CHECK;
            ST_CHECK:  state_d = ST_UPDATE;
            ST_UPDATE: state_d = win ? ST_OVER : ST_PLAY;
            ST_OVER:   state_d = ST_OVER;
            default:   state_d = ST_SETUP;
        endcase
    end

    always_comb begin
        turn_d      = turn_q ^ toggle_q;
        toggle_d    = 1'b0;
        shot_row_d  = shot_row_q;
        shot_col_d  = shot_col_q;
        code_d      = code_q;
        res_code_d  = res_code_q;
        res_valid_d = 1'b0;
        over_d      = over_q;
        winner_d    = winner_q;
        ship_cnt_d  = ship_cnt_q;
        hit_cnt_d   = hit_cnt_q;

        if (place_ok) ship_cnt_d[bus.place_player] = ship_cnt_q[bus.place_player] + 5'd1;
        if (state_q == ST_PLAY && bus.fire_valid) begin
            shot_row_d = bus.fire_row;
            shot_col_d = bus.fire_col;
        end
        if (state_q == ST_CHECK) begin
            if (shot_row_q > LAST || shot_col_q > LAST) code_d = RES_INVALID;
            else if (rd_data[target] == CELL_WATER)     code_d = RES_MISS;
            else if (rd_data[target] == CELL_SHIP)      code_d = RES_HIT;
            else                                        code_d = RES_REPEAT;
        end
        if (state_q == ST_UPDATE) begin
            res_valid_d       = 1'b1;
            res_code_d        = code_q;
            hit_cnt_d[turn_q] = hits_new;
            // The turn flips one cycle after the result, together with the buses.
            toggle_d          = shot_we && !win;
            if (win) begin
                over_d   = 1'b1;
                winner_d = turn_q;
            end
        end

        // Show the board being fired at, including a shot write landing this edge.
        rows_d = turn_d ? bank_rows[0] : bank_rows[1];
        if (shot_we) rows_d[shot_row_q][2*(GRID-1-int'(shot_col_q)) +: 2] = shot_cell;
        for (int r = 0; r < GRID; r++) begin
            for (int c = 0; c < GRID; c++) begin
                if (FOG_EN && state_d != ST_SETUP && rows_d[r][2*c +: 2] == CELL_SHIP)
                    rows_d[r][2*c +: 2] = CELL_WATER;
            end
        end
    end

    always_ff @(posedge clock50) begin
        if (reset) begin
            turn_q      <= 1'b0;
            toggle_q    <= 1'b0;
            shot_row_q  <= '0;
            shot_col_q  <= '0;
            code_q      <= RES_MISS;
            res_code_q  <= RES_MISS;
            res_valid_q <= 1'b0;
            over_q      <= 1'b0;
            winner_q    <= 1'b0;
            ship_cnt_q  <= '0;
            hit_cnt_q   <= '0;
            rows_q      <= '0;
        end else begin
            turn_q      <= turn_d;
            toggle_q    <= toggle_d;
            shot_row_q  <= shot_row_d;
            shot_col_q  <= shot_col_d;
            code_q      <= code_d;
            res_code_q  <= res_code_d;
            res_valid_q <= res_valid_d;
            over_q      <= over_d;
            winner_q    <= winner_d;
            ship_cnt_q  <= ship_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
            rows_q      <= rows_d;
        end
    end

    assign bus.fire_ready   = (state_q == ST_PLAY);
    assign bus.result_valid = res_valid_q;
    assign bus.result_code  = res_code_q;
    assign bus.playerTurn   = turn_q;
    assign bus.game_over    = over_q;
    assign bus.winner       = winner_q;
    assign bus.dbg_state    = state_q;
    assign bus.A = rows_q[0];
    assign bus.B = rows_q[1];
    assign bus.C = rows_q[2];
    assign bus.D = rows_q[3];
    assign bus.E = rows_q[4];
    assign bus.F = rows_q[5];
    assign bus.G = rows_q[6];
    assign bus.H = rows_q[7];
    assign bus.I = rows_q[8];
    assign bus.J = rows_q[9];

endmodule

// File: tb/tb_battleship_board.sv
// Directed self-checking bench for battleship_board.
module tb_battleship_board;
    import battleship_pkg::*;

    typedef logic [9:0][19:0] rows_t;

`ifdef BATTLESHIP_SHOW_SHIPS_EN
    localparam logic [1:0] SHIP_SHOWN = 2'b01;
`else
    localparam logic [1:0] SHIP_SHOWN = 2'b00;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    battleship_board_if bus();

    battleship_board dut (
        .clock50 (clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic rows_t get_rows();
        rows_t r;
        r[0] = bus.A; r[1] = bus.B; r[2] = bus.C; r[3] = bus.D; r[4] = bus.E;
        r[5] = bus.F; r[6] = bus.G; r[7] = bus.H; r[8] = bus.I; r[9] = bus.J;
        return r;
    endfunction

    task automatic place(input logic p, input logic [3:0] r, input logic [3:0] c);
        bus.place_valid  = 1'b1;
        bus.place_player = p;
        bus.place_row    = r;
        bus.place_col    = c;
        tick();
        bus.place_valid  = 1'b0;
    endtask

    // Handshake a shot, then return at T+2 (+1ns); early flags activity during CHECK/UPDATE.
    task automatic fire_shot(input logic [3:0] r, input logic [3:0] c, output logic early);
        int n;
        n = 0;
        bus.fire_valid = 1'b1;
        bus.fire_row   = r;
        bus.fire_col   = c;
        while (!bus.fire_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.fire_ready !== 1'b1) begin
            errors++;
            $display("FAIL fire_handshake_timeout: fire_ready=%0b required 1", bus.fire_ready);
        end
        tick();
        bus.fire_valid = 1'b0;
        early = bus.result_valid | bus.fire_ready;
        tick();
        early = early | bus.result_valid | bus.fire_ready;
        tick();
    endtask

    task automatic test_reset();
        rows_t obs;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (bus.dbg_state !== ST_SETUP) begin errors++; $display("FAIL reset_state: got %0d required %0d", bus.dbg_state, ST_SETUP); end
        checks++; if (bus.fire_ready !== 1'b0) begin errors++; $display("FAIL reset_fire_ready: got %b required 0", bus.fire_ready); end
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid: got %b required 0", bus.result_valid); end
        checks++; if (bus.result_code !== 2'b00) begin errors++; $display("FAIL reset_result_code: got %b required 00", bus.result_code); end
        checks++; if (bus.playerTurn !== 1'b0) begin errors++; $display("FAIL reset_player_turn: got %b required 0", bus.playerTurn); end
        checks++; if (bus.game_over !== 1'b0 || bus.winner !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b/%b required 0/0", bus.game_over, bus.winner); end
        obs = get_rows();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs[i] !== 20'h0) begin errors++; $display("FAIL reset_rows row %0d: got %h required 00000", i, obs[i]); end
        end
        reset = 1'b0;
    endtask

    task automatic test_place_limit();
        rows_t obs;
        rows_t exp_rows;
        for (int i = 0; i < 18; i++) begin
            bus.place_valid  = 1'b1;
            bus.place_player = 1'b1;
            bus.place_row    = 4'(i / 10);
            bus.place_col    = 4'(i % 10);
            tick();
            if (i == 0) begin
                checks++;
                if (bus.A !== 20'h0) begin errors++; $display("FAIL place_latency_early: A=%h required 00000", bus.A); end
            end
            if (i == 1) begin
                checks++;
                if (bus.A !== 20'h40000) begin errors++; $display("FAIL place_latency_visible: A=%h required 40000", bus.A); end
            end
        end
        bus.place_valid = 1'b0;
        tick();
        exp_rows    = '0;
        exp_rows[0] = 20'h55555;
        exp_rows[1] = 20'h55540;
        obs = get_rows();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs[i] !== exp_rows[i]) begin errors++; $display("FAIL place_limit_rows row %0d: got %h required %h", i, obs[i], exp_rows[i]); end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_guard_rails();
        place(1'b0, 4'd0, 4'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.dbg_state !== ST_SETUP || bus.fire_ready !== 1'b0) begin errors++; $display("FAIL start_no_p2_ships: state=%0d fire_ready=%b required SETUP/0", bus.dbg_state, bus.fire_ready); end
        bus.start = 1'b1;
        place(1'b1, 4'd9, 4'd9);
        bus.start = 1'b0;
        checks++; if (bus.dbg_state !== ST_SETUP) begin errors++; $display("FAIL start_with_place: state=%0d required %0d", bus.dbg_state, ST_SETUP); end
        place(1'b1, 4'd9, 4'd9);
        tick();
        checks++; if (bus.J !== 20'h00001) begin errors++; $display("FAIL setup_display_p2: J=%h required 00001", bus.J); end
    endtask

    task automatic test_place_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.dbg_state !== ST_PLAY) begin errors++; $display("FAIL start_state: got %0d required %0d", bus.dbg_state, ST_PLAY); end
        checks++; if (bus.fire_ready !== 1'b1) begin errors++; $display("FAIL start_fire_ready: got %b required 1", bus.fire_ready); end
        checks++; if (bus.J !== {18'h0, SHIP_SHOWN}) begin errors++; $display("FAIL start_fog_j: J=%h required %h", bus.J, {18'h0, SHIP_SHOWN}); end
    endtask

    task automatic test_miss();
        logic  early;
        rows_t obs;
        rows_t exp_rows;
        fire_shot(4'd3, 4'd4, early);
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL miss_busy: activity=%b during CHECK/UPDATE required 0", early); end
        checks++; if (bus.result_valid !== 1'b1 || bus.result_code !== RES_MISS) begin errors++; $display("FAIL miss_result: valid=%b code=%b required 1/00", bus.result_valid, bus.result_code); end
        checks++; if (bus.D !== 20'h00800) begin errors++; $display("FAIL miss_cell: D=%h required 00800", bus.D); end
        checks++; if (bus.playerTurn !== 1'b0) begin errors++; $display("FAIL miss_turn_t2: got %b required 0", bus.playerTurn); end
        tick();
        checks++; if (bus.playerTurn !== 1'b1 || bus.result_valid !== 1'b0) begin errors++; $display("FAIL miss_turn_t3: turn=%b valid=%b required 1/0", bus.playerTurn, bus.result_valid); end
        exp_rows    = '0;
        exp_rows[0] = {SHIP_SHOWN, 18'h0};
        obs = get_rows();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs[i] !== exp_rows[i]) begin errors++; $display("FAIL miss_p1_board row %0d: got %h required %h", i, obs[i], exp_rows[i]); end
        end
    endtask

    task automatic test_repeat_invalid();
        logic  early;
        rows_t obs;
        rows_t exp_rows;
        fire_shot(4'd5, 4'd5, early);
        checks++; if (bus.result_code !== RES_MISS || bus.F !== 20'h00200) begin errors++; $display("FAIL p2_miss: code=%b F=%h required 00/00200", bus.result_code, bus.F); end
        tick();
        checks++; if (bus.playerTurn !== 1'b0) begin errors++; $display("FAIL p2_miss_turn: got %b required 0", bus.playerTurn); end
        fire_shot(4'd3, 4'd4, early);
        checks++; if (bus.result_valid !== 1'b1 || bus.result_code !== RES_REPEAT) begin errors++; $display("FAIL repeat_result: valid=%b code=%b required 1/10", bus.result_valid, bus.result_code); end
        tick();
        checks++; if (bus.playerTurn !== 1'b0) begin errors++; $display("FAIL repeat_turn: got %b required 0", bus.playerTurn); end
        fire_shot(4'd10, 4'd2, early);
        checks++; if (bus.result_valid !== 1'b1 || bus.result_code !== RES_INVALID) begin errors++; $display("FAIL invalid_result: valid=%b code=%b required 1/11", bus.result_valid, bus.result_code); end
        tick();
        checks++; if (bus.playerTurn !== 1'b0) begin errors++; $display("FAIL invalid_turn: got %b required 0", bus.playerTurn); end
        exp_rows    = '0;
        exp_rows[3] = 20'h00800;
        exp_rows[9] = {18'h0, SHIP_SHOWN};
        obs = get_rows();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs[i] !== exp_rows[i]) begin errors++; $display("FAIL invalid_p2_board row %0d: got %h required %h", i, obs[i], exp_rows[i]); end
        end
    endtask

    task automatic test_win();
        logic early;
        int   seen;
        fire_shot(4'd9, 4'd9, early);
        checks++; if (bus.result_valid !== 1'b1 || bus.result_code !== RES_HIT) begin errors++; $display("FAIL win_result: valid=%b code=%b required 1/01", bus.result_valid, bus.result_code); end
        checks++; if (bus.J !== 20'h00003) begin errors++; $display("FAIL win_cell: J=%h required 00003", bus.J); end
        checks++; if (bus.game_over !== 1'b1 || bus.winner !== 1'b0) begin errors++; $display("FAIL win_flags: over=%b winner=%b required 1/0", bus.game_over, bus.winner); end
        checks++; if (bus.fire_ready !== 1'b0) begin errors++; $display("FAIL win_fire_ready: got %b required 0", bus.fire_ready); end
        tick();
        checks++; if (bus.dbg_state !== ST_OVER || bus.playerTurn !== 1'b0) begin errors++; $display("FAIL win_over: state=%0d turn=%b required %0d/0", bus.dbg_state, bus.playerTurn, ST_OVER); end
        seen = 0;
        bus.fire_valid = 1'b1;
        bus.fire_row   = 4'd0;
        bus.fire_col   = 4'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.result_valid || bus.fire_ready || !bus.game_over) seen++;
        end
        bus.fire_valid = 1'b0;
        checks++; if (seen !== 0) begin errors++; $display("FAIL over_frozen: %0d active cycles required 0", seen); end
    endtask

    task automatic test_reset_mid();
        rows_t obs;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        place(1'b0, 4'd0, 4'd0);
        place(1'b1, 4'd0, 4'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.dbg_state !== ST_PLAY) begin errors++; $display("FAIL reset_mid_play: state=%0d required %0d", bus.dbg_state, ST_PLAY); end
        bus.fire_valid = 1'b1;
        bus.fire_row   = 4'd0;
        bus.fire_col   = 4'd1;
        tick();
        bus.fire_valid = 1'b0;
        tick();
        checks++; if (bus.dbg_state !== ST_UPDATE) begin errors++; $display("FAIL reset_mid_update: state=%0d required %0d", bus.dbg_state, ST_UPDATE); end
        reset = 1'b1;
        tick();
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_no_pulse: valid=%b required 0", bus.result_valid); end
        checks++; if (bus.dbg_state !== ST_SETUP || bus.fire_ready !== 1'b0 || bus.playerTurn !== 1'b0) begin errors++; $display("FAIL reset_mid_ctrl: state=%0d ready=%b turn=%b required %0d/0/0", bus.dbg_state, bus.fire_ready, bus.playerTurn, ST_SETUP); end
        checks++; if (bus.game_over !== 1'b0 || bus.winner !== 1'b0 || bus.result_code !== 2'b00) begin errors++; $display("FAIL reset_mid_flags: over=%b winner=%b code=%b required 0/0/00", bus.game_over, bus.winner, bus.result_code); end
        obs = get_rows();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs[i] !== 20'h0) begin errors++; $display("FAIL reset_mid_rows row %0d: got %h required 00000", i, obs[i]); end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        bus.place_valid  = 1'b0;
        bus.place_player = 1'b0;
        bus.place_row    = 4'd0;
        bus.place_col    = 4'd0;
        bus.start        = 1'b0;
        bus.fire_valid   = 1'b0;
        bus.fire_row     = 4'd0;
        bus.fire_col     = 4'd0;

        test_reset();
        test_place_limit();
        test_guard_rails();
        test_place_start();
        test_miss();
        test_repeat_invalid();
        test_win();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
